// File: rtl/miriscv_lsu_pkg.sv
//------------------------------------------------------------------------------
// miriscv_lsu_pkg
// Shared types and byte-lane helpers for the pipelined load/store unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package miriscv_lsu_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef struct packed {
        logic       we;
        logic [2:0] size;
        logic [1:0] off;
    } lsu_meta_t;

    // size[1:0] selects the access width, size[2] marks an unsigned load
    function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] off);
        case (size[1:0])
            2'b00:   be_gen = 4'b0001 << off;
            2'b01:   be_gen = 4'b0011 << off;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_rep(input logic [2:0] size, input logic [31:0] data);
        case (size[1:0])
            2'b00:   wdata_rep = {4{data[7:0]}};
            2'b01:   wdata_rep = {2{data[15:0]}};
            default: wdata_rep = data;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] size, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] w_sh;
        w_sh = rdata >> {off, 3'b000};
        case (size[1:0])
            2'b00:   load_fmt = {{24{w_sh[7]  & ~size[2]}}, w_sh[7:0]};
            2'b01:   load_fmt = {{16{w_sh[15] & ~size[2]}}, w_sh[15:0]};
            default: load_fmt = rdata;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/miriscv_sync_fifo.sv
//------------------------------------------------------------------------------
// miriscv_sync_fifo
// Generic synchronous FIFO with full/empty/count; reads are combinational.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module miriscv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        ptr_next = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    // Overflowing pushes and underflowing pops are dropped so the count never wraps
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= ptr_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/miriscv_lsu_pipelined.sv
//------------------------------------------------------------------------------
// miriscv_lsu_pipelined
// Multi-outstanding load/store unit with in-order responses, misalignment
// detection, bus error reporting and kill of un-granted requests. XLEN must be 32.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module miriscv_lsu_pipelined
    import miriscv_lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int RESP_REG = 0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [XLEN-1:0]   lsu_addr_i,
    input  logic [XLEN-1:0]   lsu_data_i,
    input  logic              lsu_kill_i,
    output logic              lsu_accept_o,
    output logic              lsu_stall_o,
    output logic              lsu_misaligned_o,
    output logic              lsu_rvalid_o,
    output logic              lsu_rwe_o,
    output logic [XLEN-1:0]   lsu_rdata_o,
    output logic              lsu_err_o,
    output logic              lsu_busy_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic              data_we_o,
    output logic [XLEN/8-1:0] data_be_o,
    output logic [XLEN-1:0]   data_addr_o,
    output logic [XLEN-1:0]   data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [XLEN-1:0]   data_rdata_i,
    input  logic              data_err_i
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int META_W = $bits(lsu_meta_t);

    logic              w_misaligned;
    logic              w_accept;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [META_W-1:0] w_fifo_rdata;
    lsu_meta_t         w_push_meta;
    lsu_meta_t         w_pop_meta;
    logic [XLEN-1:0]   w_rdata_fmt;

    assign w_misaligned = (((lsu_size_i == MEM_H) || (lsu_size_i == MEM_HU)) && lsu_addr_i[0])
                        || ((lsu_size_i == MEM_W) && (lsu_addr_i[1:0] != 2'b00));

    // Full blocks issue regardless of a same-cycle pop, keeping rvalid off the req path
    assign data_req_o       = lsu_req_i & ~lsu_kill_i & ~w_misaligned & ~w_full;
    assign w_accept         = data_req_o & data_gnt_i;
    assign lsu_accept_o     = w_accept;
    assign lsu_misaligned_o = lsu_req_i & w_misaligned;
    assign lsu_stall_o      = lsu_req_i & ~w_accept & ~w_misaligned & ~lsu_kill_i;
    assign lsu_busy_o       = (w_count != '0);

    assign data_we_o    = lsu_we_i;
    assign data_be_o    = be_gen(lsu_size_i, lsu_addr_i[1:0]);
    assign data_addr_o  = {lsu_addr_i[XLEN-1:2], 2'b00};
    assign data_wdata_o = wdata_rep(lsu_size_i, lsu_data_i);

    assign w_push_meta.we   = lsu_we_i;
    assign w_push_meta.size = lsu_size_i;
    assign w_push_meta.off  = lsu_addr_i[1:0];

    miriscv_sync_fifo #(
        .WIDTH (META_W),
        .DEPTH (DEPTH)
    ) u_meta_fifo (
        .clk     (clk_i),
        .rst     (arst_i),
        .i_push  (w_accept),
        .i_wdata (w_push_meta),
        .i_pop   (data_rvalid_i),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_pop       = data_rvalid_i & ~w_empty;
    assign w_pop_meta  = lsu_meta_t'(w_fifo_rdata);
    assign w_rdata_fmt = (w_pop && !data_err_i && !w_pop_meta.we)
                       ? load_fmt(w_pop_meta.size, w_pop_meta.off, data_rdata_i) : '0;

    if (RESP_REG != 0) begin : g_resp_reg
        logic            r_rvalid;
        logic            r_rwe;
        logic            r_err;
        logic [XLEN-1:0] r_rdata;

        always_ff @(posedge clk_i or posedge arst_i) begin
            if (arst_i) begin
                r_rvalid <= 1'b0;
                r_rwe    <= 1'b0;
                r_err    <= 1'b0;
                r_rdata  <= '0;
            end else begin
                r_rvalid <= w_pop;
                r_rwe    <= w_pop & w_pop_meta.we;
                r_err    <= w_pop & data_err_i;
                r_rdata  <= w_rdata_fmt;
            end
        end

        assign lsu_rvalid_o = r_rvalid;
        assign lsu_rwe_o    = r_rwe;
        assign lsu_err_o    = r_err;
        assign lsu_rdata_o  = r_rdata;
    end else begin : g_resp_comb
        assign lsu_rvalid_o = w_pop;
        assign lsu_rwe_o    = w_pop & w_pop_meta.we;
        assign lsu_err_o    = w_pop & data_err_i;
        assign lsu_rdata_o  = w_rdata_fmt;
    end

    // A response with nothing outstanding means the memory broke the protocol
    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (arst_i)
        !(data_rvalid_i && w_empty));

endmodule

`default_nettype wire

// File: tb/tb_miriscv_lsu_pipelined.sv
//------------------------------------------------------------------------------
// tb_miriscv_lsu_pipelined
// Directed self-checking bench for the pipelined LSU (DEPTH=2, RESP_REG=0).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_miriscv_lsu_pipelined;

    logic        clk_i;
    logic        arst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic        lsu_kill_i;
    logic        lsu_accept_o;
    logic        lsu_stall_o;
    logic        lsu_misaligned_o;
    logic        lsu_rvalid_o;
    logic        lsu_rwe_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic        lsu_busy_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    int err_cnt = 0;
    int chk_cnt = 0;

    localparam logic [2:0] c_B  = 3'b000;
    localparam logic [2:0] c_H  = 3'b001;
    localparam logic [2:0] c_W  = 3'b010;
    localparam logic [2:0] c_BU = 3'b100;

    miriscv_lsu_pipelined #(
        .XLEN     (32),
        .DEPTH    (2),
        .RESP_REG (0)
    ) u_dut (
        .clk_i            (clk_i),
        .arst_i           (arst_i),
        .lsu_req_i        (lsu_req_i),
        .lsu_we_i         (lsu_we_i),
        .lsu_size_i       (lsu_size_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_data_i       (lsu_data_i),
        .lsu_kill_i       (lsu_kill_i),
        .lsu_accept_o     (lsu_accept_o),
        .lsu_stall_o      (lsu_stall_o),
        .lsu_misaligned_o (lsu_misaligned_o),
        .lsu_rvalid_o     (lsu_rvalid_o),
        .lsu_rwe_o        (lsu_rwe_o),
        .lsu_rdata_o      (lsu_rdata_o),
        .lsu_err_o        (lsu_err_o),
        .lsu_busy_o       (lsu_busy_o),
        .data_req_o       (data_req_o),
        .data_gnt_i       (data_gnt_i),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_addr_o      (data_addr_o),
        .data_wdata_o     (data_wdata_o),
        .data_rvalid_i    (data_rvalid_i),
        .data_rdata_i     (data_rdata_i),
        .data_err_i       (data_err_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns later
    task automatic set_in(input logic req, input logic we, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd, input logic kill,
                          input logic gnt, input logic rv, input logic [31:0] rd,
                          input logic er);
        @(negedge clk_i);
        lsu_req_i     = req;
        lsu_we_i      = we;
        lsu_size_i    = sz;
        lsu_addr_i    = addr;
        lsu_data_i    = wd;
        lsu_kill_i    = kill;
        data_gnt_i    = gnt;
        data_rvalid_i = rv;
        data_rdata_i  = rd;
        data_err_i    = er;
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, c_W, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        arst_i = 1'b1;
        lsu_req_i = 0; lsu_we_i = 0; lsu_size_i = c_W; lsu_addr_i = 0; lsu_data_i = 0;
        lsu_kill_i = 0; data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0; data_err_i = 0;
        #2;
        check("rst_busy",   32'(lsu_busy_o),   32'h0);
        check("rst_rvalid", 32'(lsu_rvalid_o), 32'h0);
        check("rst_req",    32'(data_req_o),   32'h0);
        idle();
        arst_i = 1'b0;

        // lw 0x100, zero-wait grant and response
        set_in(1, 0, c_W, 32'h100, 32'h0, 0, 1, 0, 32'h0, 0);
        check("lw_req",    32'(data_req_o),   32'h1);
        check("lw_accept", 32'(lsu_accept_o), 32'h1);
        check("lw_be",     32'(data_be_o),    32'hF);
        check("lw_addr",   data_addr_o,       32'h100);
        set_in(0, 0, c_W, 32'h0, 32'h0, 0, 0, 1, 32'hDEADBEEF, 0);
        check("lw_rvalid", 32'(lsu_rvalid_o), 32'h1);
        check("lw_rdata",  lsu_rdata_o,       32'hDEADBEEF);
        idle();
        check("lw_busy0",  32'(lsu_busy_o),   32'h0);

        // lb / lbu at byte 3, sh at half 1
        set_in(1, 0, c_B, 32'h103, 32'h0, 0, 1, 0, 32'h0, 0);
        check("lb_be",   32'(data_be_o),  32'h8);
        check("lb_addr", data_addr_o,     32'h100);
        set_in(0, 0, c_W, 32'h0, 32'h0, 0, 0, 1, 32'h80112233, 0);
        check("lb_rdata", lsu_rdata_o,    32'hFFFFFF80);
        set_in(1, 0, c_BU, 32'h103, 32'h0, 0, 1, 0, 32'h0, 0);
        check("lbu_be",  32'(data_be_o),  32'h8);
        set_in(0, 0, c_W, 32'h0, 32'h0, 0, 0, 1, 32'h80112233, 0);
        check("lbu_rdata", lsu_rdata_o,   32'h00000080);
        set_in(1, 1, c_H, 32'h102, 32'h0000ABCD, 0, 1, 0, 32'h0, 0);
        check("sh_be",    32'(data_be_o),   32'hC);
        check("sh_wdata", data_wdata_o,     32'hABCDABCD);
        check("sh_we",    32'(data_we_o),   32'h1);
        set_in(0, 0, c_W, 32'h0, 32'h0, 0, 0, 1, 32'h12345678, 0);
        check("sh_rwe",   32'(lsu_rwe_o),   32'h1);
        check("sh_rdata", lsu_rdata_o,      32'h0);

        // Two outstanding fill the queue; third request stalls until a slot frees
        set_in(1, 0, c_W, 32'h200, 32'h0, 0, 1, 0, 32'h0, 0);
        check("q_acc0", 32'(lsu_accept_o), 32'h1);
        set_in(1, 0, c_BU, 32'h205, 32'h0, 0, 1, 0, 32'h0, 0);
        check("q_acc1", 32'(lsu_accept_o), 32'h1);
        check("q_be1",  32'(data_be_o),    32'h2);
        set_in(1, 0, c_H, 32'h20A, 32'h0, 0, 1, 0, 32'h0, 0);
        check("q_full_req",   32'(data_req_o),  32'h0);
        check("q_full_stall", 32'(lsu_stall_o), 32'h1);
        set_in(1, 0, c_H, 32'h20A, 32'h0, 0, 1, 1, 32'h11111111, 0);
        check("q_pop_req",  32'(data_req_o),   32'h0);
        check("q_pop_stall", 32'(lsu_stall_o), 32'h1);
        check("q_r0",       lsu_rdata_o,       32'h11111111);
        set_in(1, 0, c_H, 32'h20A, 32'h0, 0, 1, 1, 32'h0000AB00, 0);
        check("q_acc2", 32'(lsu_accept_o), 32'h1);
        check("q_be2",  32'(data_be_o),    32'hC);
        check("q_r1",   lsu_rdata_o,       32'h000000AB);
        set_in(0, 0, c_W, 32'h0, 32'h0, 0, 0, 1, 32'h80000000, 0);
        check("q_rv2",  32'(lsu_rvalid_o), 32'h1);
        check("q_r2",   lsu_rdata_o,       32'hFFFF8000);
        idle();
        check("q_busy0", 32'(lsu_busy_o),  32'h0);

        // Misaligned word and half are never issued
        set_in(1, 0, c_W, 32'h102, 32'h0, 0, 1, 0, 32'h0, 0);
        check("mis_w",     32'(lsu_misaligned_o), 32'h1);
        check("mis_w_req", 32'(data_req_o),       32'h0);
        check("mis_w_stall", 32'(lsu_stall_o),    32'h0);
        set_in(1, 0, c_H, 32'h101, 32'h0, 0, 1, 0, 32'h0, 0);
        check("mis_h",     32'(lsu_misaligned_o), 32'h1);
        check("mis_h_acc", 32'(lsu_accept_o),     32'h0);
        idle();
        check("mis_busy0", 32'(lsu_busy_o),       32'h0);
        check("mis_none",  32'(lsu_rvalid_o),     32'h0);

        // Kill before grant drops the request; kill after grant does not
        set_in(1, 0, c_W, 32'h300, 32'h0, 0, 0, 0, 32'h0, 0);
        check("kw_stall0", 32'(lsu_stall_o), 32'h1);
        set_in(1, 0, c_W, 32'h300, 32'h0, 0, 0, 0, 32'h0, 0);
        check("kw_acc1",   32'(lsu_accept_o), 32'h0);
        set_in(1, 0, c_W, 32'h300, 32'h0, 1, 1, 0, 32'h0, 0);
        check("kill_req",   32'(data_req_o),   32'h0);
        check("kill_stall", 32'(lsu_stall_o),  32'h0);
        idle();
        check("kill_busy0", 32'(lsu_busy_o),   32'h0);
        set_in(1, 0, c_W, 32'h304, 32'h0, 0, 1, 0, 32'h0, 0);
        check("kg_acc", 32'(lsu_accept_o), 32'h1);
        set_in(1, 0, c_W, 32'h304, 32'h0, 1, 1, 0, 32'h0, 0);
        check("kg_busy", 32'(lsu_busy_o),  32'h1);
        set_in(0, 0, c_W, 32'h0, 32'h0, 0, 0, 1, 32'h12345678, 0);
        check("kg_rvalid", 32'(lsu_rvalid_o), 32'h1);
        check("kg_rdata",  lsu_rdata_o,       32'h12345678);

        // Store with bus error
        set_in(1, 1, c_W, 32'h400, 32'hCAFEF00D, 0, 1, 0, 32'h0, 0);
        check("sw_wdata", data_wdata_o, 32'hCAFEF00D);
        set_in(0, 0, c_W, 32'h0, 32'h0, 0, 0, 1, 32'hFFFFFFFF, 1);
        check("se_err",   32'(lsu_err_o), 32'h1);
        check("se_rwe",   32'(lsu_rwe_o), 32'h1);
        check("se_rdata", lsu_rdata_o,    32'h0);

        // Asynchronous reset with two transactions outstanding
        set_in(1, 0, c_W, 32'h500, 32'h0, 0, 1, 0, 32'h0, 0);
        set_in(1, 0, c_W, 32'h504, 32'h0, 0, 1, 0, 32'h0, 0);
        set_in(0, 0, c_W, 32'h0, 32'h0, 0, 0, 1, 32'h55555555, 1);
        check("ar_busy1",   32'(lsu_busy_o),   32'h1);
        check("ar_rvalid1", 32'(lsu_rvalid_o), 32'h1);
        arst_i = 1'b1;
        #1;
        check("ar_busy0",   32'(lsu_busy_o),   32'h0);
        check("ar_rvalid0", 32'(lsu_rvalid_o), 32'h0);
        check("ar_err0",    32'(lsu_err_o),    32'h0);
        check("ar_rdata0",  lsu_rdata_o,       32'h0);
        idle();
        arst_i = 1'b0;
        idle();
        check("ar_after",   32'(lsu_busy_o),   32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/miriscv_lsu_pipelined.md
Name: miriscv_lsu_pipelined

Overview:
- Next-generation load/store unit for the miriscv core. It replaces the single-outstanding, blocking LSU used inside the decode stage.
- Parametrised in data width and in the number of outstanding memory transactions (grant/rvalid handshake, in-order responses).
- Adds misalignment detection, bus error reporting and kill of a not-yet-granted request.
- Sits between the decode/execute datapath and the data memory port.

Parameters:
- XLEN, 32: data/address width; must be 32 (byte-lane logic is 4-lane).
- DEPTH, 2: maximum outstanding (granted, not yet responded) transactions; 1..8.
- RESP_REG, 0: 1 registers the response outputs, adding 1 cycle of latency.

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- lsu_req_i  in  1  core request valid
- lsu_we_i  in  1  1 = store
- lsu_size_i  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- lsu_addr_i  in  XLEN  byte address
- lsu_data_i  in  XLEN  store data, right-aligned
- lsu_kill_i  in  1  drop the current un-granted request
- lsu_accept_o  out  1  request granted this cycle
- lsu_stall_o  out  1  lsu_req_i & ~lsu_accept_o & ~lsu_misaligned_o & ~lsu_kill_i
- lsu_misaligned_o  out  1  current request misaligned; it is not issued
- lsu_rvalid_o  out  1  response valid, one per accepted request, in order
- lsu_rwe_o  out  1  response belongs to a store
- lsu_rdata_o  out  XLEN  formatted load data; 0 for stores
- lsu_err_o  out  1  bus error on this response
- lsu_busy_o  out  1  outstanding count != 0
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory grant
- data_we_o  out  1  write enable
- data_be_o  out  XLEN/8  byte enables
- data_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- data_wdata_o  out  XLEN  lane-replicated store data
- data_rvalid_i  in  1  memory response valid
- data_rdata_i  in  XLEN  memory read data
- data_err_i  in  1  memory error, qualified by data_rvalid_i

Behaviour:
- Reset (async, arst_i=1): tracking queue empty, count=0, all registered outputs 0.
- Misaligned request: H/HU with addr[0]=1, or W with addr[1:0]!=0. lsu_misaligned_o=1 combinationally, data_req_o=0, nothing is queued.
- Request issue:
  - data_req_o = lsu_req_i & ~lsu_kill_i & ~misaligned & ~full.
  - Accept when data_req_o & data_gnt_i; lsu_accept_o equals that condition.
  - Address, wdata and be are held combinationally from the inputs. The core must hold them stable until accept.
- Full: count==DEPTH blocks data_req_o, even when data_rvalid_i pops in the same cycle. This keeps rvalid-to-req free of any combinational path.
- Tracking queue: DEPTH-entry FIFO of meta {we, size, addr[1:0]}.
  - Push on accept, pop on data_rvalid_i.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- data_rvalid_i with an empty queue is a protocol violation: ignored, count stays 0, flagged by an assertion.
- Byte enables: B/BU 0001<<addr[1:0]; H/HU 0011<<addr[1:0]; W 1111.
- Write data lanes: B replicates data[7:0] ×4; H replicates data[15:0] ×2; W passes through.
- Load formatting uses the popped meta:
  - Byte/half extracted at offset addr[1:0]×8.
  - Sign-extended for B/H, zero-extended for BU/HU.
- Response:
  - RESP_REG=0: lsu_rvalid_o = data_rvalid_i & ~empty, same cycle.
  - RESP_REG=1: one cycle later, from flops.
  - lsu_err_o = data_err_i. lsu_rdata_o = 0 when lsu_err_o or lsu_rwe_o.
- Kill: affects only a not-yet-granted request. Granted transactions always complete and return responses.
- Minimum latency: request to lsu_rvalid_o is 1 cycle with a 0-wait memory (RESP_REG=0).

Decomposition:
- miriscv_lsu_pkg holds:
  - mem_size_e (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU);
  - lsu_meta_t struct;
  - be/replicate helper functions.
- Sub-module miriscv_sync_fifo: generic parametrised width/depth FIFO with full, empty and count outputs, reused for the tracking queue.

Test Plan:
- Reset, then lw addr 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF → lsu_rvalid_o=1, lsu_rdata_o=0xDEADBEEF, lsu_busy_o back to 0.
- lb addr 0x103 and lbu addr 0x103, rdata 0x80112233 → be=1000, rdata 0xFFFFFF80 and 0x00000080 respectively; sh addr 0x102, data 0x0000ABCD → be=1100, wdata 0xABCDABCD.
- DEPTH=2: three back-to-back lw with gnt held 1 and rvalid delayed 3 cycles → third request stalls (data_req_o=0, lsu_stall_o=1) until the first rvalid; responses arrive in issue order.
- lw addr 0x102 → lsu_misaligned_o=1, data_req_o=0, no response; lh addr 0x101 → same.
- lsu_req_i with gnt=0 for 2 cycles, then lsu_kill_i=1 → no accept, count stays 0; a kill after grant still yields one rvalid.
- Store with data_err_i=1 on rvalid → lsu_err_o=1, lsu_rwe_o=1, lsu_rdata_o=0; assert arst_i mid-flight with 2 outstanding → count=0 and all outputs 0 asynchronously.
